time_counter: RTL
=================

# time_counter

Timekeeping core of the digital clock, sitting directly downstream of the 1 Hz divider. It consumes the one-cycle `sec_tick` pulse and keeps hours, minutes and seconds as registered BCD digits for the display stage. It also provides pause, direct load and per-field increment controls for the button/set logic. Rollover pulses are exported for alarm and chime logic.

## Interface
Parameters:
- `HOUR_MODE`, 24: 24 gives hours 00–23; 12 gives hours 01–12 with a `pm` flag. Any other value is illegal.

Ports:
- `clk`  input  1  system clock, 100 MHz.
- `rst`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `sec_tick`  input  1  one-cycle pulse once per second from the divider.
- `run_en`  input  1  1 = count on `sec_tick`; 0 = paused, `sec_tick` ignored.
- `inc_min`  input  1  one-cycle request to add one minute.
- `inc_hour`  input  1  one-cycle request to add one hour.
- `load_en`  input  1  one-cycle request to load the `load_*` values.
- `load_hh`  input  8  BCD hours {tens, units}.
- `load_mm`  input  8  BCD minutes.
- `load_ss`  input  8  BCD seconds.
- `load_pm`  input  1  PM flag for a load. Used only when `HOUR_MODE`=12.
- `hh`, `mm`, `ss`  output  8 each  current time in BCD {tens[7:4], units[3:0]}.
- `pm`  output  1  PM indicator. Constant 0 when `HOUR_MODE`=24.
- `min_tick`  output  1  one-cycle pulse when seconds roll 59→00 through counting.
- `hour_tick`  output  1  one-cycle pulse when minutes roll 59→00 through counting.
- `day_tick`  output  1  one-cycle pulse on the day rollover: 23:59:59→00:00:00, or 11:59:59 PM→12:00:00 AM.
- `load_err`  output  1  one-cycle pulse when a load is rejected.

## Operation
- Every output is a register. Units and tens digits are kept as separate 4-bit counters, with no binary-to-BCD conversion.
- Each cycle performs exactly one action, chosen by strict priority:
  - `rst`: time = 00:00:00 (24 h) or 12:00:00 with `pm`=0 (12 h). All tick outputs and `load_err` = 0.
  - `load_en`: check the load values, then either load them or reject them.
    - Valid means every nibble ≤ 9, `load_mm` ≤ 0x59, `load_ss` ≤ 0x59, and hours are 0x00–0x23 (24 h) or 0x01–0x12 (12 h).
    - Valid: `hh`/`mm`/`ss`/`pm` take the load values.
    - Invalid: time is unchanged and `load_err`=1 for one cycle.
  - `inc_hour`: hours +1.
    - 24 h: 23→00.
    - 12 h: 11→12 toggles `pm`; 12→01.
    - `mm` and `ss` are untouched. No tick outputs fire.
  - `inc_min`: minutes +1, with 59→00 and no carry into hours. `ss` is cleared to 00. No tick outputs fire.
  - `sec_tick` with `run_en`=1: count one second.
    - `ss` +1. At 59 it wraps to 00, `mm` +1 and `min_tick`=1.
    - `mm` at 59 wraps to 00, hours +1 and `hour_tick`=1.
    - Hours wrap per mode, as for `inc_hour`.
    - `day_tick`=1 on a 23→00 wrap (24 h), or on the 11→12 step that sets `pm`=0 (12 h).
- Lower-priority requests in the same cycle are dropped, not queued. A `sec_tick` coinciding with any control action is lost.
- With `inc_hour` and `inc_min` high together, only hours change.
- With `run_en`=0, the time holds and no tick fires. Load and inc still work.

## Timing
- Latency from input to output is 1 cycle: action sampled at edge N, new values visible after edge N.
- `min_tick`, `hour_tick` and `day_tick` are asserted in the same cycle that the new wrapped values appear. Each is exactly one cycle wide.
- `sec_tick` pulses are at least 1 s apart, so back-to-back carries never overlap.
- `rst` asserted mid-count takes effect at the next edge regardless of any other input.
- Hold BCD digits in valid range at all times. An illegal state must not be reachable through any input sequence.

## Test plan
- Reset, HOUR_MODE=24: assert `rst` with `sec_tick`=1 and `load_en`=1 → 00:00:00 and all pulses 0. Release, give 61 `sec_tick` → 00:01:01 and exactly one `min_tick`.
- Day rollover, 24 h: load 23:59:58, give 2 ticks → 23:59:59, then 00:00:00 with `min_tick`, `hour_tick` and `day_tick` all high in the same single cycle.
- 12 h mode: load 11:59:59 with `pm`=0, give 1 tick → 12:00:00 `pm`=1, `day_tick`=0. Load 11:59:59 with `pm`=1, give 1 tick → 12:00:00 `pm`=0, `day_tick`=1. `inc_hour` from 12 → 01 with `pm` unchanged.
- Load validation:
  - load 0x24:00:00 in 24 h → `load_err` pulses, time unchanged.
  - load 0x12:0x5A:00 → rejected.
  - load 0x00:00:00 in 12 h → rejected.
  - load 0x09:0x30:0x15 → accepted.
- Adjust priority: at 10:59:30, `inc_min` and `sec_tick` in the same cycle → 10:00:00, no tick pulses. `inc_hour` and `inc_min` together → only hour +1.
- Pause: `run_en`=0, give 5 ticks → time unchanged, no pulses. Then `run_en`=1, give 1 tick → `ss` +1.

Source files
------------

// File: rtl/time_counter.sv
// Timekeeping core: BCD hours/minutes/seconds driven by a 1 Hz tick,
// with pause, validated direct load, per-field increment and rollover pulses.
module time_counter #(
  parameter int HOUR_MODE = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       run_en,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       load_en,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       load_err
);

  localparam bit MODE12 = (HOUR_MODE == 12);

  if (HOUR_MODE != 12 && HOUR_MODE != 24) begin : g_bad_mode
    $error("time_counter: HOUR_MODE must be 12 or 24");
  end

  // Separate units/tens digit registers; the 8-bit ports are their concatenation.
  logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
  logic       pm_r;

  logic [7:0] hh_n, mm_n, ss_n;
  logic       pm_n, min_n, hour_n, day_n, err_n;
  logic [9:0] hr_step;

  assign hh = {hh_t, hh_u};
  assign mm = {mm_t, mm_u};
  assign ss = {ss_t, ss_u};
  assign pm = pm_r;

  // Advance a BCD 00..59 field by one, wrapping 59 -> 00.
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Advance hours by one; returns {day_wrap, pm_next, hh_next}.
  // In 12 h mode 11 -> 12 toggles pm, and only the PM -> AM toggle is a new day.
  function automatic logic [9:0] hour_inc(input logic [7:0] h, input logic p);
    logic [7:0] hn;
    logic       pn;
    logic       d;
    hn = (h[3:0] == 4'd9) ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
    pn = p;
    d  = 1'b0;
    if (MODE12) begin
      if (h == 8'h12) begin
        hn = 8'h01;
      end else if (h == 8'h11) begin
        pn = ~p;
        d  = p;
      end
    end else if (h == 8'h23) begin
      hn = 8'h00;
      d  = 1'b1;
    end
    return {d, pn, hn};
  endfunction

  // A load is accepted only if every digit is decimal and each field is in range,
  // which keeps every reachable state a legal time.
  function automatic logic load_ok(input logic [7:0] h, input logic [7:0] m,
                                   input logic [7:0] s);
    logic digits;
    logic hours;
    digits = (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
             (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9) &&
             (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
    if (MODE12)
      hours = (h >= 8'h01) && (h <= 8'h12);
    else
      hours = (h <= 8'h23);
    return digits && hours;
  endfunction

  assign hr_step = hour_inc(hh, pm_r);

  // Select the single action for this cycle by priority and form the next state.
  always_comb begin
    hh_n   = hh;
    mm_n   = mm;
    ss_n   = ss;
    pm_n   = pm_r;
    min_n  = 1'b0;
    hour_n = 1'b0;
    day_n  = 1'b0;
    err_n  = 1'b0;
    if (load_en) begin
      if (load_ok(load_hh, load_mm, load_ss)) begin
        hh_n = load_hh;
        mm_n = load_mm;
        ss_n = load_ss;
        pm_n = MODE12 ? load_pm : 1'b0;
      end else begin
        err_n = 1'b1;
      end
    end else if (inc_hour) begin
      hh_n = hr_step[7:0];
      pm_n = hr_step[8];
    end else if (inc_min) begin
      mm_n = bcd60_inc(mm);
      ss_n = 8'h00;
    end else if (sec_tick && run_en) begin
      ss_n = bcd60_inc(ss);
      if (ss == 8'h59) begin
        min_n = 1'b1;
        mm_n  = bcd60_inc(mm);
        if (mm == 8'h59) begin
          hour_n = 1'b1;
          hh_n   = hr_step[7:0];
          pm_n   = hr_step[8];
          day_n  = hr_step[9];
        end
      end
    end
  end

  // State and pulse registers; reset forces midnight and clears all pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      {hh_t, hh_u} <= MODE12 ? 8'h12 : 8'h00;
      {mm_t, mm_u} <= 8'h00;
      {ss_t, ss_u} <= 8'h00;
      pm_r         <= 1'b0;
      min_tick     <= 1'b0;
      hour_tick    <= 1'b0;
      day_tick     <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      {hh_t, hh_u} <= hh_n;
      {mm_t, mm_u} <= mm_n;
      {ss_t, ss_u} <= ss_n;
      pm_r         <= pm_n;
      min_tick     <= min_n;
      hour_tick    <= hour_n;
      day_tick     <= day_n;
      load_err     <= err_n;
    end
  end

endmodule
